wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone (pipelined) arbiter sharing simple_mem between
//  the instruction-fetch port (m0) and the load/store port (m1). Grants the slave
//  per bus cycle (cyc), routes strobes down and ack/err/data back to the owner only,
//  and tracks outstanding requests so a cycle is never torn mid-flight.
// PARAMETERS
//  PRIO_FIXED      0   0: round-robin on ties; 1: fixed priority, m0 always wins ties
//  MAX_OUTSTANDING 15  strobes accepted but not yet acked (max 15, 4-bit counter)
//  TIMEOUT_CYCLES  16  stall-free wait limit for ack/err (used only with WB_ARB_TIMEOUT_EN)
// PORTS  (N = 0,1; AW = `XLEN-`XLEN_GRAN, DW = `XLEN, SW = `XLEN/8)
//  clk_i        in   1   clock
//  rst_ni       in   1   reset, synchronous, active-low
//  mN_cyc_i     in   1   master N bus cycle
//  mN_stb_i     in   1   master N strobe
//  mN_we_i      in   1   master N write enable
//  mN_addr_i    in   AW  master N word address
//  mN_sel_i     in   SW  master N byte selects
//  mN_dat_i     in   DW  master N write data
//  mN_ack_o     out  1   ack to master N
//  mN_err_o     out  1   error to master N
//  mN_stall_o   out  1   stall to master N
//  mN_dat_o     out  DW  read data to master N (s_dat_i broadcast)
//  s_cyc_o/s_stb_o/s_we_o  out 1   to slave, muxed from owner
//  s_addr_o/s_sel_o/s_dat_o out AW/SW/DW  to slave, muxed from owner
//  s_ack_i/s_err_i/s_stall_i in 1  from slave
//  s_dat_i      in   DW  read data from slave
// BEHAVIOUR
//  - States IDLE, OWN0, OWN1. Reset: IDLE, outstanding=0, last_owner=1.
//  - Reset outputs: all mN_ack_o/mN_err_o=0, mN_stall_o=1, s_cyc_o=s_stb_o=0.
//  - IDLE: all mN_stall_o=1, s_cyc_o=0. Any mN_cyc_i=1 -> OWNN next edge (1-cycle
//    arbitration latency). Both: PRIO_FIXED=1 -> m0; else the master != last_owner.
//  - OWNN: s_* = mN_*; mN_stall_o = s_stall_i | (outstanding==MAX_OUTSTANDING);
//    s_stb_o masked to 0 when counter full. Non-owner: stall=1, ack=err=0.
//  - mN_ack_o = owner & s_ack_i; mN_err_o = owner & s_err_i (combinational).
//  - outstanding: +1 on s_stb_o & !s_stall_i, -1 on s_ack_i|s_err_i, both -> hold.
//    Never underflows: ack/err with outstanding==0 ignored, not forwarded.
//  - Owner drops mN_cyc_i: s_cyc_o drops same cycle; -> IDLE next edge,
//    last_owner=N, outstanding cleared; late acks/errs discarded, never to other master.
//  - Releasing cycle cannot re-grant; earliest new grant is edge after IDLE.
//  - rst_ni=0 mid-transfer: all regs reset at the edge, in-flight acks dropped.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined: counter runs while outstanding>0 and no ack/err,
//    cleared on ack/err; at TIMEOUT_CYCLES pulse owner mN_err_o for 1 cycle, clear
//    outstanding, force IDLE (s_cyc_o low >=1 cycle) regardless of mN_cyc_i.
//  Not defined: no counter; arbiter waits for ack/err indefinitely.
// TESTING
//  1 m0 read 0x10, m1 idle -> s_cyc_o 1 cycle after m0_cyc_i; m0_ack_o mirrors s_ack_i; m1_ack_o stays 0.
//  2 PRIO_FIXED=0, both cyc from reset -> m0 first; after m0 drops cyc m1 granted 2 cycles later; next tie -> m0.
//  3 PRIO_FIXED=1, m0 re-requests back-to-back, m1 held -> m0 wins every tie; m1 granted only when m0_cyc_i idle.
//  4 m1 burst 4 stbs, no stall -> outstanding 1..4, 4 acks to m1, counter 0; 16th unacked stb -> m1_stall_o=1.
//  5 m0 drops cyc with 2 outstanding, m1 waiting -> 2 late s_ack_i not on m0/m1_ack_o; m1 granted.
//  6 WB_ARB_TIMEOUT_EN, slave never acks, TIMEOUT_CYCLES=16 -> m0_err_o 1-cycle pulse 16 cycles after stb, IDLE; without macro none.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of simple_mem (m0 = ifetch, m1 = load/store).
// Optional feature macro: WB_ARB_TIMEOUT_EN aborts a bus cycle whose ack/err never arrives.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module wb_mem_arbiter #(
    parameter int unsigned PRIO_FIXED      = 0,
    parameter int unsigned MAX_OUTSTANDING = 15,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            m0_cyc_i,
    input  logic                            m0_stb_i,
    input  logic                            m0_we_i,
    input  logic [`XLEN-`XLEN_GRAN-1:0]     m0_addr_i,
    input  logic [`XLEN/8-1:0]              m0_sel_i,
    input  logic [`XLEN-1:0]                m0_dat_i,
    output logic                            m0_ack_o,
    output logic                            m0_err_o,
    output logic                            m0_stall_o,
    output logic [`XLEN-1:0]                m0_dat_o,
    input  logic                            m1_cyc_i,
    input  logic                            m1_stb_i,
    input  logic                            m1_we_i,
    input  logic [`XLEN-`XLEN_GRAN-1:0]     m1_addr_i,
    input  logic [`XLEN/8-1:0]              m1_sel_i,
    input  logic [`XLEN-1:0]                m1_dat_i,
    output logic                            m1_ack_o,
    output logic                            m1_err_o,
    output logic                            m1_stall_o,
    output logic [`XLEN-1:0]                m1_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [`XLEN-`XLEN_GRAN-1:0]     s_addr_o,
    output logic [`XLEN/8-1:0]              s_sel_o,
    output logic [`XLEN-1:0]                s_dat_o,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_stall_i,
    input  logic [`XLEN-1:0]                s_dat_i
);

    localparam int unsigned CW = 4;

    // The outstanding counter is 4 bits wide; reject configurations it cannot hold.
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_outstanding
        $error("wb_mem_arbiter: MAX_OUTSTANDING must be in 1..15");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wb_mem_arbiter: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic            last_owner_q, last_owner_d;

    logic            own0_c;
    logic            own1_c;
    logic            full_c;
    logic            rsp_valid_c;
    logic            stb_accept_c;
    logic            release_c;
    logic            tmo_fire_c;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]   tmo_q, tmo_d;

    // Fires on the last stall-free cycle before the limit, with nothing answered yet.
    always_comb begin
        tmo_fire_c = (state_q != IDLE) && (outstanding_q != '0) && !s_ack_i && !s_err_i
                     && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        tmo_d      = tmo_q + TW'(1);
        if (state_q == IDLE || outstanding_q == '0 || s_ack_i || s_err_i || release_c) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire_c = 1'b0;
`endif

    // Slave-side mux and per-master response routing.
    always_comb begin
        own0_c       = (state_q == OWN0) && m0_cyc_i;
        own1_c       = (state_q == OWN1) && m1_cyc_i;
        full_c       = (outstanding_q == CW'(MAX_OUTSTANDING));
        rsp_valid_c  = (outstanding_q != '0);

        s_cyc_o      = own0_c || own1_c;
        s_stb_o      = ((own0_c && m0_stb_i) || (own1_c && m1_stb_i)) && !full_c && !tmo_fire_c;
        s_we_o       = (state_q == OWN1) ? m1_we_i   : m0_we_i;
        s_addr_o     = (state_q == OWN1) ? m1_addr_i : m0_addr_i;
        s_sel_o      = (state_q == OWN1) ? m1_sel_i  : m0_sel_i;
        s_dat_o      = (state_q == OWN1) ? m1_dat_i  : m0_dat_i;
        stb_accept_c = s_stb_o && !s_stall_i;

        m0_stall_o   = (state_q != OWN0) || s_stall_i || full_c || tmo_fire_c;
        m1_stall_o   = (state_q != OWN1) || s_stall_i || full_c || tmo_fire_c;
        m0_ack_o     = own0_c && s_ack_i && rsp_valid_c;
        m1_ack_o     = own1_c && s_ack_i && rsp_valid_c;
        m0_err_o     = ((state_q == OWN0) && tmo_fire_c) || (own0_c && s_err_i && rsp_valid_c);
        m1_err_o     = ((state_q == OWN1) && tmo_fire_c) || (own1_c && s_err_i && rsp_valid_c);
        m0_dat_o     = s_dat_i;
        m1_dat_o     = s_dat_i;
    end

    // Grant, release and outstanding-count bookkeeping.
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        outstanding_d = outstanding_q;
        release_c     = 1'b0;

        if (stb_accept_c && !(s_ack_i || s_err_i)) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!stb_accept_c && (s_ack_i || s_err_i) && rsp_valid_c) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = ((PRIO_FIXED != 0) || last_owner_q) ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i || tmo_fire_c) begin
                    release_c    = 1'b1;
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i || tmo_fire_c) begin
                    release_c    = 1'b1;
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Responses still in flight at release belong to nobody.
        if (release_c) begin
            outstanding_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            last_owner_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            last_owner_q  <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed scoreboard bench for wb_mem_arbiter: round-robin instance (dut) and fixed-priority
// instance (dut_p) share all inputs; WB_ARB_TIMEOUT_EN selects the expected timeout behaviour.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module tb_wb_mem_arbiter;

    localparam int unsigned DW = `XLEN;
    localparam int unsigned AW = `XLEN - `XLEN_GRAN;
    localparam int unsigned SW = `XLEN / 8;

    logic          clk;
    logic          rst_ni;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_addr;
    logic [SW-1:0] m0_sel;
    logic [DW-1:0] m0_wdat;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_addr;
    logic [SW-1:0] m1_sel;
    logic [DW-1:0] m1_wdat;
    logic          s_ack_i, s_err_i, s_stall_i;
    logic [DW-1:0] s_rdat;

    logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_wdat;

    logic          p_m0_ack, p_m0_err, p_m0_stall, p_m1_ack, p_m1_err, p_m1_stall;
    logic [DW-1:0] p_m0_rdat, p_m1_rdat;
    logic          p_s_cyc, p_s_stb, p_s_we;
    logic [AW-1:0] p_s_addr;
    logic [SW-1:0] p_s_sel;
    logic [DW-1:0] p_s_wdat;

    typedef struct {
        int unsigned   m;
        logic [AW-1:0] addr;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    wb_mem_arbiter #(.PRIO_FIXED(0), .MAX_OUTSTANDING(15), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_sel_o(s_sel), .s_dat_o(s_wdat),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_rdat)
    );

    wb_mem_arbiter #(.PRIO_FIXED(1), .MAX_OUTSTANDING(15), .TIMEOUT_CYCLES(16)) dut_p (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_ack_o(p_m0_ack), .m0_err_o(p_m0_err),
        .m0_stall_o(p_m0_stall), .m0_dat_o(p_m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_ack_o(p_m1_ack), .m1_err_o(p_m1_err),
        .m1_stall_o(p_m1_stall), .m1_dat_o(p_m1_rdat),
        .s_cyc_o(p_s_cyc), .s_stb_o(p_s_stb), .s_we_o(p_s_we), .s_addr_o(p_s_addr),
        .s_sel_o(p_s_sel), .s_dat_o(p_s_wdat),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return DW'(a) ^ DW'(32'hA5A5_5A5A);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_sel = '1; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b1; m1_addr = '0; m1_sel = '1; m1_wdat = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0; s_rdat = '0;
        step();
        step();
        rst_ni = 1'b1;
        sb.delete();
    endtask

    // One accepted strobe from master m; the expected response is queued.
    task automatic strobe(input int unsigned m, input logic [AW-1:0] a);
        sb_t e;
        if (m == 0) begin m0_stb = 1'b1; m0_addr = a; end
        else        begin m1_stb = 1'b1; m1_addr = a; end
        look();
        check("stb_out", 64'(s_stb), 64'(1));
        check("stb_addr", 64'(s_addr), 64'(a));
        check("owner_stall", 64'((m == 0) ? m0_stall : m1_stall), 64'(0));
        e.m = m;
        e.addr = a;
        sb.push_back(e);
        step();
        m0_stb = 1'b0;
        m1_stb = 1'b0;
    endtask

    // Slave answers the oldest queued strobe with ack (or err); only its master may see it.
    task automatic respond(input bit is_err);
        sb_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            s_ack_i = !is_err;
            s_err_i = is_err;
            s_rdat  = rdata(e.addr);
            look();
            check("rsp_ack_m0", 64'(m0_ack), 64'((e.m == 0) && !is_err));
            check("rsp_ack_m1", 64'(m1_ack), 64'((e.m == 1) && !is_err));
            check("rsp_err_m0", 64'(m0_err), 64'((e.m == 0) && is_err));
            check("rsp_err_m1", 64'(m1_err), 64'((e.m == 1) && is_err));
            check("rsp_data", 64'((e.m == 0) ? m0_rdat : m1_rdat), 64'(rdata(e.addr)));
            step();
            s_ack_i = 1'b0;
            s_err_i = 1'b0;
        end
    endtask

    initial begin
        bit exp_err;
        bit exp_cyc;

        // Reset state
        do_reset();
        rst_ni = 1'b0;
        step();
        look();
        check("rst_m0_stall", 64'(m0_stall), 64'(1));
        check("rst_m1_stall", 64'(m1_stall), 64'(1));
        check("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'(0));
        check("rst_s_cyc", 64'(s_cyc), 64'(0));
        check("rst_s_stb", 64'(s_stb), 64'(0));

        // 1: m0 alone, one-cycle arbitration latency, ack only to m0
        do_reset();
        m0_cyc = 1'b1;
        look();
        check("t1_latency_cyc", 64'(s_cyc), 64'(0));
        check("t1_latency_stall", 64'(m0_stall), 64'(1));
        step();
        look();
        check("t1_granted", 64'(s_cyc), 64'(1));
        check("t1_m1_stall", 64'(m1_stall), 64'(1));
        strobe(0, AW'('h10));
        respond(1'b0);
        m0_cyc = 1'b0;
        look();
        check("t1_cyc_drop", 64'(s_cyc), 64'(0));
        step();
        step();

        // 2: round-robin ties
        do_reset();
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        look();
        check("t2_latency", 64'(s_cyc), 64'(0));
        step();
        look();
        check("t2_tie_m0", 64'(m0_stall), 64'(0));
        check("t2_tie_m1_held", 64'(m1_stall), 64'(1));
        check("t2_p_tie_m0", 64'(p_m0_stall), 64'(0));
        strobe(0, AW'('h20));
        respond(1'b0);
        m0_cyc = 1'b0;
        look();
        check("t2_cyc_drop", 64'(s_cyc), 64'(0));
        step();
        look();
        check("t2_idle_gap", 64'(s_cyc), 64'(0));
        check("t2_idle_m1_stall", 64'(m1_stall), 64'(1));
        step();
        look();
        check("t2_m1_granted", 64'(m1_stall), 64'(0));
        check("t2_m1_cyc", 64'(s_cyc), 64'(1));
        strobe(1, AW'('h30));
        respond(1'b0);
        m1_cyc = 1'b0;
        m0_cyc = 1'b1;
        step();
        m1_cyc = 1'b1;
        look();
        check("t2_tie2_idle", 64'(s_cyc), 64'(0));
        step();
        look();
        check("t2_tie2_m0", 64'(m0_stall), 64'(0));
        check("t2_tie2_m1_held", 64'(m1_stall), 64'(1));
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        step();
        step();

        // 3: fixed priority, m0 re-requests back-to-back while m1 waits
        do_reset();
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        step();
        look();
        check("t3_p_first_m0", 64'(p_m0_stall), 64'(0));
        m0_cyc = 1'b0;
        step();
        m0_cyc = 1'b1;
        look();
        check("t3_p_idle1", 64'(p_s_cyc), 64'(0));
        step();
        look();
        check("t3_p_rewin1", 64'(p_m0_stall), 64'(0));
        check("t3_p_m1_held1", 64'(p_m1_stall), 64'(1));
        check("t3_rr_gives_m1", 64'(m1_stall), 64'(0));
        check("t3_rr_m0_held", 64'(m0_stall), 64'(1));
        m0_cyc = 1'b0;
        step();
        m0_cyc = 1'b1;
        look();
        check("t3_p_idle2", 64'(p_s_cyc), 64'(0));
        step();
        look();
        check("t3_p_rewin2", 64'(p_m0_stall), 64'(0));
        check("t3_p_m1_held2", 64'(p_m1_stall), 64'(1));
        m0_cyc = 1'b0;
        step();
        look();
        check("t3_p_idle3", 64'(p_s_cyc), 64'(0));
        step();
        look();
        check("t3_p_m1_granted", 64'(p_m1_stall), 64'(0));
        check("t3_p_m0_stall", 64'(p_m0_stall), 64'(1));
        check("t3_p_cyc", 64'(p_s_cyc), 64'(1));
        m1_cyc = 1'b0;
        step();
        step();

        // 4: m1 burst, outstanding tracking and the full-counter stall
        do_reset();
        m1_cyc = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            strobe(1, AW'(32'h40 + 32'(k)));
            check("t4_out_up", 64'(dut.outstanding_q), 64'(k));
        end
        for (int k = 1; k <= 4; k++) begin
            respond(1'b0);
            check("t4_out_down", 64'(dut.outstanding_q), 64'(4 - k));
        end
        for (int k = 1; k <= 15; k++) begin
            strobe(1, AW'(32'h80 + 32'(k)));
        end
        m1_stb = 1'b1;
        look();
        check("t4_full_stall", 64'(m1_stall), 64'(1));
        check("t4_full_stb_mask", 64'(s_stb), 64'(0));
        step();
        m1_stb = 1'b0;
        m1_cyc = 1'b0;
        sb.delete();
        step();
        check("t4_out_cleared", 64'(dut.outstanding_q), 64'(0));
        step();

        // 5: m0 abandons two outstanding reads; late acks reach nobody, m1 takes over
        do_reset();
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        step();
        strobe(0, AW'('h50));
        strobe(0, AW'('h54));
        check("t5_out_two", 64'(dut.outstanding_q), 64'(2));
        m0_cyc = 1'b0;
        look();
        check("t5_cyc_drop", 64'(s_cyc), 64'(0));
        step();
        sb.delete();
        s_ack_i = 1'b1;
        look();
        check("t5_late1_acks", 64'({m0_ack, m1_ack}), 64'(0));
        step();
        look();
        check("t5_late2_acks", 64'({m0_ack, m1_ack}), 64'(0));
        check("t5_m1_granted", 64'(m1_stall), 64'(0));
        step();
        s_ack_i = 1'b0;
        check("t5_out_zero", 64'(dut.outstanding_q), 64'(0));
        strobe(1, AW'('h60));
        respond(1'b1);
        m1_cyc = 1'b0;
        step();
        step();

        // 6: slave never answers
        do_reset();
        m0_cyc = 1'b1;
        step();
        strobe(0, AW'('h70));
        for (int i = 1; i <= 24; i++) begin
`ifdef WB_ARB_TIMEOUT_EN
            exp_err = (i == 16);
            exp_cyc = (i != 17);
`else
            exp_err = 1'b0;
            exp_cyc = 1'b1;
`endif
            look();
            check("t6_m0_err", 64'(m0_err), 64'(exp_err));
            check("t6_s_cyc", 64'(s_cyc), 64'(exp_cyc));
            check("t6_m1_err", 64'(m1_err), 64'(0));
            step();
        end
        m0_cyc = 1'b0;
        sb.delete();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
